sys_array_fetcher: RTL and testbench
====================================

Name: sys_array_fetcher

Overview:
Top-level matrix-multiply engine that computes OUT = W x B for whole matrices presented on wide parallel buses.
The matrices are larger than the physical systolic grid, so the block tiles the work.
It latches both operands on start, streams ARRAY_MAX_W x ARRAY_MAX_L tiles through an output-stationary systolic MAC grid with skewed feeding, and collects the tile results into a full result matrix.
It signals completion on ready.

Parameters:
DATA_WIDTH, 8, bit width of each operand element (unsigned).
ARRAY_W_W, 20, rows of W and rows of OUT.
ARRAY_W_L, 10, columns of W (inner dimension K); must equal ARRAY_A_W.
ARRAY_A_W, 10, rows of B (inner dimension K).
ARRAY_A_L, 10, columns of B and columns of OUT.
ARRAY_MAX_W, 10, physical PE grid rows.
ARRAY_MAX_L, 10, physical PE grid columns.
ARRAY_MAX_A_L, 10, maximum supported K; elaboration error if ARRAY_W_L exceeds it.
OUT_SIZE, 100, element capacity of the per-tile result buffer; must be at least ARRAY_MAX_W*ARRAY_MAX_L (elaboration check).

Ports:
clk  in  1  system clock; all logic is rising-edge.
reset_n  in  1  synchronous, active-low reset.
start_comp  in  1  start request; level, sampled each clk.
input_data_w  in  [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0]  matrix W, row-major, element [0][0] at the MSB end.
input_data_b  in  [0:ARRAY_A_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0]  matrix B, same packing.
ready  out  1  result valid / engine idle-with-result.
out_data  out  [0:ARRAY_W_W-1][0:ARRAY_A_L-1][2*DATA_WIDTH-1:0]  result matrix OUT.

Behaviour:
- Reset (reset_n low at a clk edge): FSM goes to IDLE, ready=0, out_data all zero, accumulators cleared. Reset mid-computation aborts the computation; no partial result is kept.
- Arithmetic:
  - OUT[i][j] = sum over k of W[i][k]*B[k][j].
  - Unsigned product and accumulation in 2*DATA_WIDTH bits, wrapping modulo 2^(2*DATA_WIDTH). No saturation.
- Tiling:
  - TR = ceil(ARRAY_W_W/ARRAY_MAX_W) row tiles, TC = ceil(ARRAY_A_L/ARRAY_MAX_L) column tiles, T = TR*TC.
  - Tile order is row-tile major, column-tile minor.
  - Out-of-range W rows and B columns in a partial tile are fed as zero and their results are discarded.
- FSM states:
  - IDLE: waits. When start_comp=1 at an edge, latches input_data_w and input_data_b into internal registers, clears ready, and goes to CLEAR. start_comp=0 keeps IDLE.
  - CLEAR (1 cycle): zero all PE accumulators and go to FEED.
  - FEED (K+ARRAY_MAX_W+ARRAY_MAX_L-1 cycles): on feed cycle t, grid row r receives W[tile_r+r][t-r] and grid column c receives B[t-c][tile_c+c]. The operand is zero when the index is outside 0..K-1. Operands propagate one PE right/down per cycle, and each PE accumulates a*b. Then go to STORE.
  - STORE (1 cycle): copy valid accumulators into out_data at the tile offsets. Go to CLEAR for the next tile, or to DONE after the last tile.
  - DONE: ready=1, out_data held stable. start_comp=1 re-latches inputs, clears ready, and goes to CLEAR. Out_data keeps its old value until overwritten tile by tile.
- Latency: ready rises 1 + T*(K+ARRAY_MAX_W+ARRAY_MAX_L+1) edges after the edge that samples start_comp. Defaults give T=2 and 63 cycles.
- start_comp is ignored in CLEAR/FEED/STORE; holding it high for several cycles starts exactly one computation.
- Input buses may change after the latching edge without affecting the result.
- ready is low from the latching edge until completion and never pulses during a computation.

Decomposition:
- Package sys_array_pkg holds the element, accumulator and tile-index typedefs, the FSM state enum, and the derived constants TR, TC, T, K and FEED_CYCLES.
- One sub-module, sys_array_pe: a single MAC processing element with a_in/b_in, registered a_out/b_out, and accumulator clear/enable.
- sys_array_fetcher holds the grid generate loop, the operand latches, the skew/feed muxing, the FSM and the result buffer.

Test Plan:
- W and B all ones with defaults, start held 6 cycles: ready rises exactly 63 cycles after the start edge; every out_data element = 10; ready stays 1 afterwards.
- W rows 0-9 = identity and rows 10-19 = 2×identity, B[k][j]=k*10+j: OUT rows 0-9 = B and rows 10-19 = 2*B, which checks tile placement.
- All elements 0xFF: every OUT element = 0xEC0A (650250 mod 65536), which checks wrap.
- Random W and B compared against a golden model, then a second start with new data: second result correct; ready drops on the start edge and rises 63 cycles later.
- Pulse reset_n low for 1 cycle 20 cycles into a computation: ready=0 and out_data=0 the next cycle; a subsequent start gives the correct result with full latency.
- ARRAY_W_W=15 and ARRAY_A_L=7 (partial tiles), random data: matches the golden model; padded lanes leave no effect.

Source files
------------

// File: rtl/sys_array_pkg.sv
// Shared element/accumulator types, FSM encoding and default tiling geometry
// for the output-stationary systolic matrix engine.
package sys_array_pkg;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_ARRAY_W_W     = 20;
    localparam int DEF_ARRAY_W_L     = 10;
    localparam int DEF_ARRAY_A_W     = 10;
    localparam int DEF_ARRAY_A_L     = 10;
    localparam int DEF_ARRAY_MAX_W   = 10;
    localparam int DEF_ARRAY_MAX_L   = 10;
    localparam int DEF_ARRAY_MAX_A_L = 10;
    localparam int DEF_OUT_SIZE      = 100;

    function automatic int ceilDiv(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int bitsFor(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    // Derived tiling figures for the default geometry
    localparam int K           = DEF_ARRAY_W_L;
    localparam int TR          = ceilDiv(DEF_ARRAY_W_W, DEF_ARRAY_MAX_W);
    localparam int TC          = ceilDiv(DEF_ARRAY_A_L, DEF_ARRAY_MAX_L);
    localparam int T           = TR * TC;
    localparam int FEED_CYCLES = K + DEF_ARRAY_MAX_W + DEF_ARRAY_MAX_L - 1;

    typedef logic [DEF_DATA_WIDTH-1:0]   elem_t;
    typedef logic [2*DEF_DATA_WIDTH-1:0] acc_t;
    typedef logic [7:0]                  tile_idx_t;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_CLEAR = 3'd1;
    localparam state_t S_FEED  = 3'd2;
    localparam state_t S_STORE = 3'd3;
    localparam state_t S_DONE  = 3'd4;

endpackage

// File: rtl/sys_array_pe.sv
// One multiply-accumulate cell of the systolic grid: operands pass through
// one register stage right/down while the product accumulates locally.
module sys_array_pe
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic [DATA_WIDTH-1:0]   a_in,
    input  logic [DATA_WIDTH-1:0]   b_in,
    output logic [DATA_WIDTH-1:0]   a_out,
    output logic [DATA_WIDTH-1:0]   b_out,
    output logic [2*DATA_WIDTH-1:0] acc_o
);

    localparam int ACC_W = 2 * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic [ACC_W-1:0]      acc_q;
    logic [ACC_W-1:0]      prod;

    assign prod = ACC_W'(a_in) * ACC_W'(b_in);

    // Clearing also flushes the operand stages so a new tile starts from zeros
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (clr_i) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (en_i) begin
            a_q   <= a_in;
            b_q   <= b_in;
            acc_q <= acc_q + prod;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/sys_array_fetcher.sv
// Tiled matrix multiply OUT = W x B: latches both operands, streams grid-sized
// tiles through the skew-fed MAC array and assembles the full result matrix.
module sys_array_fetcher
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ARRAY_W_W     = DEF_ARRAY_W_W,
    parameter int ARRAY_W_L     = DEF_ARRAY_W_L,
    parameter int ARRAY_A_W     = DEF_ARRAY_A_W,
    parameter int ARRAY_A_L     = DEF_ARRAY_A_L,
    parameter int ARRAY_MAX_W   = DEF_ARRAY_MAX_W,
    parameter int ARRAY_MAX_L   = DEF_ARRAY_MAX_L,
    parameter int ARRAY_MAX_A_L = DEF_ARRAY_MAX_A_L,
    parameter int OUT_SIZE      = DEF_OUT_SIZE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start_comp,
    input  logic [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0]   input_data_w,
    input  logic [0:ARRAY_A_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0]   input_data_b,
    output logic ready,
    output logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][2*DATA_WIDTH-1:0] out_data
);

    localparam int ACC_W     = 2 * DATA_WIDTH;
    localparam int K_DIM     = ARRAY_W_L;
    localparam int ROW_TILES = ceilDiv(ARRAY_W_W, ARRAY_MAX_W);
    localparam int COL_TILES = ceilDiv(ARRAY_A_L, ARRAY_MAX_L);
    localparam int FEED_LEN  = K_DIM + ARRAY_MAX_W + ARRAY_MAX_L - 1;
    localparam int CNT_W     = bitsFor(FEED_LEN);
    localparam int TR_W      = bitsFor(ROW_TILES);
    localparam int TC_W      = bitsFor(COL_TILES);

    if (ARRAY_W_L > ARRAY_MAX_A_L) begin : gKTooLarge
        $error("sys_array_fetcher: ARRAY_W_L exceeds ARRAY_MAX_A_L");
    end
    if (ARRAY_W_L != ARRAY_A_W) begin : gKMismatch
        $error("sys_array_fetcher: ARRAY_W_L must equal ARRAY_A_W");
    end
    if (OUT_SIZE < ARRAY_MAX_W * ARRAY_MAX_L) begin : gOutTooSmall
        $error("sys_array_fetcher: OUT_SIZE smaller than one grid tile");
    end

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  feedCnt_q, feedCnt_d;
    logic [TR_W-1:0]   tileR_q, tileR_d;
    logic [TC_W-1:0]   tileC_q, tileC_d;
    logic              ready_q, ready_d;
    logic              latchEn;

    logic [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0] wLat_q;
    logic [0:ARRAY_A_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0] bLat_q;
    logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][ACC_W-1:0]      out_q, out_d;

    logic [DATA_WIDTH-1:0] wTile   [ROW_TILES][ARRAY_MAX_W][K_DIM];
    logic [DATA_WIDTH-1:0] bTile   [COL_TILES][ARRAY_MAX_L][K_DIM];
    logic [DATA_WIDTH-1:0] aFeed   [ARRAY_MAX_W];
    logic [DATA_WIDTH-1:0] bFeed   [ARRAY_MAX_L];
    logic [DATA_WIDTH-1:0] aLink   [ARRAY_MAX_W][ARRAY_MAX_L+1];
    logic [DATA_WIDTH-1:0] bLink   [ARRAY_MAX_W+1][ARRAY_MAX_L];
    logic [ACC_W-1:0]      accGrid [ARRAY_MAX_W][ARRAY_MAX_L];

    always_comb begin
        state_d   = state_q;
        feedCnt_d = feedCnt_q;
        tileR_d   = tileR_q;
        tileC_d   = tileC_q;
        ready_d   = ready_q;
        latchEn   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_comp) begin
                    latchEn = 1'b1;
                    ready_d = 1'b0;
                    tileR_d = '0;
                    tileC_d = '0;
                    state_d = S_CLEAR;
                end else if (state_q == S_DONE) begin
                    ready_d = 1'b1;
                end
            end
            S_CLEAR: begin
                feedCnt_d = '0;
                state_d   = S_FEED;
            end
            S_FEED: begin
                if (feedCnt_q == CNT_W'(FEED_LEN - 1)) begin
                    state_d = S_STORE;
                end else begin
                    feedCnt_d = feedCnt_q + CNT_W'(1);
                end
            end
            S_STORE: begin
                state_d = S_CLEAR;
                if (tileC_q == TC_W'(COL_TILES - 1)) begin
                    tileC_d = '0;
                    if (tileR_q == TR_W'(ROW_TILES - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        tileR_d = tileR_q + TR_W'(1);
                    end
                end else begin
                    tileC_d = tileC_q + TC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            feedCnt_q <= '0;
            tileR_q   <= '0;
            tileC_q   <= '0;
            ready_q   <= 1'b0;
            wLat_q    <= '0;
            bLat_q    <= '0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            feedCnt_q <= feedCnt_d;
            tileR_q   <= tileR_d;
            tileC_q   <= tileC_d;
            ready_q   <= ready_d;
            out_q     <= out_d;
            if (latchEn) begin
                wLat_q <= input_data_w;
                bLat_q <= input_data_b;
            end
        end
    end

    // Zero-padded per-tile views so lanes past the matrix edge feed zeros
    for (genvar tr = 0; tr < ROW_TILES; tr++) begin : gWTile
        for (genvar r = 0; r < ARRAY_MAX_W; r++) begin : gRow
            for (genvar k = 0; k < K_DIM; k++) begin : gK
                if (tr * ARRAY_MAX_W + r < ARRAY_W_W) begin : gIn
                    assign wTile[tr][r][k] = wLat_q[tr*ARRAY_MAX_W+r][k];
                end else begin : gPad
                    assign wTile[tr][r][k] = '0;
                end
            end
        end
    end

    for (genvar tc = 0; tc < COL_TILES; tc++) begin : gBTile
        for (genvar c = 0; c < ARRAY_MAX_L; c++) begin : gCol
            for (genvar k = 0; k < K_DIM; k++) begin : gK
                if (tc * ARRAY_MAX_L + c < ARRAY_A_L) begin : gIn
                    assign bTile[tc][c][k] = bLat_q[k][tc*ARRAY_MAX_L+c];
                end else begin : gPad
                    assign bTile[tc][c][k] = '0;
                end
            end
        end
    end

    // Skewed injection: lane n sees element k on feed cycle k + n
    always_comb begin
        for (int r = 0; r < ARRAY_MAX_W; r++) begin
            aFeed[r] = '0;
            for (int k = 0; k < K_DIM; k++) begin
                if (feedCnt_q == CNT_W'(k + r)) aFeed[r] = wTile[tileR_q][r][k];
            end
        end
        for (int c = 0; c < ARRAY_MAX_L; c++) begin
            bFeed[c] = '0;
            for (int k = 0; k < K_DIM; k++) begin
                if (feedCnt_q == CNT_W'(k + c)) bFeed[c] = bTile[tileC_q][c][k];
            end
        end
    end

    for (genvar r = 0; r < ARRAY_MAX_W; r++) begin : gAEdge
        assign aLink[r][0] = aFeed[r];
    end
    for (genvar c = 0; c < ARRAY_MAX_L; c++) begin : gBEdge
        assign bLink[0][c] = bFeed[c];
    end

    for (genvar r = 0; r < ARRAY_MAX_W; r++) begin : gGridRow
        for (genvar c = 0; c < ARRAY_MAX_L; c++) begin : gGridCol
            sys_array_pe #(.DATA_WIDTH(DATA_WIDTH)) uPe (
                .clk     (clk),
                .reset_n (reset_n),
                .clr_i   (state_q == S_CLEAR),
                .en_i    (state_q == S_FEED),
                .a_in    (aLink[r][c]),
                .b_in    (bLink[r][c]),
                .a_out   (aLink[r][c+1]),
                .b_out   (bLink[r+1][c]),
                .acc_o   (accGrid[r][c])
            );
        end
    end

    // Each result element is owned by exactly one tile and one PE
    for (genvar i = 0; i < ARRAY_W_W; i++) begin : gOutRow
        for (genvar j = 0; j < ARRAY_A_L; j++) begin : gOutCol
            assign out_d[i][j] = (state_q == S_STORE
                                  && tileR_q == TR_W'(i / ARRAY_MAX_W)
                                  && tileC_q == TC_W'(j / ARRAY_MAX_L))
                                 ? accGrid[i % ARRAY_MAX_W][j % ARRAY_MAX_L]
                                 : out_q[i][j];
        end
    end

    assign ready    = ready_q;
    assign out_data = out_q;

endmodule

// File: tb/tb_sys_array_fetcher.sv
// Directed scoreboard bench for sys_array_fetcher: default 20x10x10 geometry
// plus a 15x10x7 instance that exercises partial tiles.
module tb_sys_array_fetcher;
    import sys_array_pkg::*;

    localparam int WW      = 20;
    localparam int KD      = 10;
    localparam int AL      = 10;
    localparam int PW      = 15;
    localparam int PL      = 7;
    localparam int EXP_LAT = 63;

    typedef logic [0:WW-1][0:KD-1][7:0]  wMat_t;
    typedef logic [0:KD-1][0:AL-1][7:0]  bMat_t;
    typedef logic [0:WW-1][0:AL-1][15:0] oMat_t;
    typedef logic [0:PW-1][0:KD-1][7:0]  wPMat_t;
    typedef logic [0:KD-1][0:PL-1][7:0]  bPMat_t;
    typedef logic [0:PW-1][0:PL-1][15:0] oPMat_t;

    logic   clk = 1'b0;
    logic   reset_n, start, startP, ready, readyP;
    wMat_t  wBus;
    bMat_t  bBus;
    oMat_t  outBus;
    wPMat_t wPBus;
    bPMat_t bPBus;
    oPMat_t outPBus;

    int     total = 0;
    int     bad   = 0;
    int     lat;
    oMat_t  expQ[$];
    oPMat_t expPQ[$];
    wMat_t  wTmp;
    bMat_t  bTmp;

    always #5 clk = ~clk;

    sys_array_fetcher dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_comp   (start),
        .input_data_w (wBus),
        .input_data_b (bBus),
        .ready        (ready),
        .out_data     (outBus)
    );

    sys_array_fetcher #(.ARRAY_W_W(PW), .ARRAY_A_L(PL)) dutP (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_comp   (startP),
        .input_data_w (wPBus),
        .input_data_b (bPBus),
        .ready        (readyP),
        .out_data     (outPBus)
    );

    function automatic oMat_t golden(input wMat_t w, input bMat_t b);
        oMat_t res;
        acc_t  acc;
        for (int i = 0; i < WW; i++)
            for (int j = 0; j < AL; j++) begin
                acc = '0;
                for (int k = 0; k < KD; k++) acc = acc + acc_t'(w[i][k]) * acc_t'(b[k][j]);
                res[i][j] = acc;
            end
        return res;
    endfunction

    function automatic oPMat_t goldenP(input wPMat_t w, input bPMat_t b);
        oPMat_t res;
        acc_t   acc;
        for (int i = 0; i < PW; i++)
            for (int j = 0; j < PL; j++) begin
                acc = '0;
                for (int k = 0; k < KD; k++) acc = acc + acc_t'(w[i][k]) * acc_t'(b[k][j]);
                res[i][j] = acc;
            end
        return res;
    endfunction

    function automatic wMat_t randW();
        wMat_t m;
        for (int i = 0; i < WW; i++) for (int k = 0; k < KD; k++) m[i][k] = 8'($urandom);
        return m;
    endfunction

    function automatic bMat_t randB();
        bMat_t m;
        for (int k = 0; k < KD; k++) for (int j = 0; j < AL; j++) m[k][j] = 8'($urandom);
        return m;
    endfunction

    function automatic wPMat_t randWP();
        wPMat_t m;
        for (int i = 0; i < PW; i++) for (int k = 0; k < KD; k++) m[i][k] = 8'($urandom);
        return m;
    endfunction

    function automatic bPMat_t randBP();
        bPMat_t m;
        for (int k = 0; k < KD; k++) for (int j = 0; j < PL; j++) m[k][j] = 8'($urandom);
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input wMat_t w, input bMat_t b);
        wBus = w;
        bBus = b;
        expQ.push_back(golden(w, b));
    endtask

    task automatic applyStimulusP(input wPMat_t w, input bPMat_t b);
        wPBus = w;
        bPBus = b;
        expPQ.push_back(goldenP(w, b));
    endtask

    // Raise start before an edge, hold it for 'hold' sampling edges, scramble the
    // buses once latched, and measure edges until ready rises.
    task automatic startAndWait(input bit isP, input int hold, output int latency);
        @(negedge clk);
        if (isP) startP = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput(isP ? "ready low after start P" : "ready low after start",
                    32'(isP ? readyP : ready), 32'd0);
        if (isP) begin
            wPBus = randWP();
            bPBus = randBP();
        end else begin
            wBus = randW();
            bBus = randB();
        end
        latency = -1;
        for (int n = 1; n <= 200; n++) begin
            if (n >= hold) begin
                start  = 1'b0;
                startP = 1'b0;
            end
            @(posedge clk);
            #1;
            if ((isP ? readyP : ready) === 1'b1) begin
                latency = n;
                break;
            end
        end
        checkOutput(isP ? "latency P" : "latency", 32'(latency), 32'(EXP_LAT));
    endtask

    task automatic checkResult(input string tag);
        oMat_t exp;
        checkOutput({tag, " scoreboard depth"}, 32'(expQ.size()), 32'd1);
        if (expQ.size() > 0) begin
            exp = expQ.pop_front();
            for (int i = 0; i < WW; i++)
                for (int j = 0; j < AL; j++)
                    checkOutput($sformatf("%s out[%0d][%0d]", tag, i, j),
                                32'(outBus[i][j]), 32'(exp[i][j]));
        end
    endtask

    task automatic checkResultP(input string tag);
        oPMat_t exp;
        checkOutput({tag, " scoreboard depth"}, 32'(expPQ.size()), 32'd1);
        if (expPQ.size() > 0) begin
            exp = expPQ.pop_front();
            for (int i = 0; i < PW; i++)
                for (int j = 0; j < PL; j++)
                    checkOutput($sformatf("%s outP[%0d][%0d]", tag, i, j),
                                32'(outPBus[i][j]), 32'(exp[i][j]));
        end
    endtask

    task automatic checkZero(input string tag);
        for (int i = 0; i < WW; i++)
            for (int j = 0; j < AL; j++)
                checkOutput($sformatf("%s out[%0d][%0d]", tag, i, j), 32'(outBus[i][j]), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        startP  = 1'b0;
        wBus    = '0;
        bBus    = '0;
        wPBus   = '0;
        bPBus   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset ready", 32'(ready), 32'd0);
        checkOutput("reset readyP", 32'(readyP), 32'd0);
        checkZero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] all-ones operands, start held 6 cycles");
        for (int i = 0; i < WW; i++) for (int k = 0; k < KD; k++) wTmp[i][k] = 8'd1;
        for (int k = 0; k < KD; k++) for (int j = 0; j < AL; j++) bTmp[k][j] = 8'd1;
        applyStimulus(wTmp, bTmp);
        startAndWait(1'b0, 6, lat);
        checkResult("ones");
        checkOutput("ones out[7][4]", 32'(outBus[7][4]), 32'd10);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("ready holds", 32'(ready), 32'd1);

        $display("[TB] identity / double-identity placement");
        for (int i = 0; i < WW; i++)
            for (int k = 0; k < KD; k++)
                wTmp[i][k] = ((i % 10) == k) ? ((i < 10) ? 8'd1 : 8'd2) : 8'd0;
        for (int k = 0; k < KD; k++) for (int j = 0; j < AL; j++) bTmp[k][j] = 8'(k * 10 + j);
        applyStimulus(wTmp, bTmp);
        startAndWait(1'b0, 1, lat);
        checkResult("ident");
        checkOutput("ident out[4][7]", 32'(outBus[4][7]), 32'd47);
        checkOutput("ident out[15][3]", 32'(outBus[15][3]), 32'd106);

        $display("[TB] all 0xFF operands, accumulator wrap");
        for (int i = 0; i < WW; i++) for (int k = 0; k < KD; k++) wTmp[i][k] = 8'hFF;
        for (int k = 0; k < KD; k++) for (int j = 0; j < AL; j++) bTmp[k][j] = 8'hFF;
        applyStimulus(wTmp, bTmp);
        startAndWait(1'b0, 2, lat);
        checkResult("wrap");
        checkOutput("wrap out[19][9]", 32'(outBus[19][9]), 32'h0000EC0A);

        $display("[TB] random operands, then restart from DONE");
        applyStimulus(randW(), randB());
        startAndWait(1'b0, 1, lat);
        checkResult("rand1");
        applyStimulus(randW(), randB());
        startAndWait(1'b0, 3, lat);
        checkResult("rand2");

        $display("[TB] reset pulse mid-computation");
        wBus = randW();
        bBus = randB();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort ready", 32'(ready), 32'd0);
        checkZero("abort");
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(randW(), randB());
        startAndWait(1'b0, 1, lat);
        checkResult("post-abort");

        $display("[TB] partial tiles 15x7");
        applyStimulusP(randWP(), randBP());
        startAndWait(1'b1, 2, lat);
        checkResultP("partial");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
